rf_port_sched: RTL

Shares the register file's single-mode access port (read two registers or write one register per clock) between one read requester and two write-back requesters (wb0, wb1). It provides valid/ready handshakes, round-robin fairness, read-after-write ordering and a post-reset clear sequence. It sits between the issue/write-back stages and the register file, and drives all of the register file's control pins.

---
 rtl/rf_port_sched_pkg.sv | 19 +
 rtl/rf_port_sched_if.sv | 41 ++++
 rtl/rf_port_sched_arb3.sv | 56 +++++
 rtl/rf_port_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rf_port_sched_pkg.sv
// rf_port_sched shared types: requester slots, FSM states, default widths.
// Optional build macro RF_SCHED_X0_ZERO_EN (hard-wired zero register).
package rf_sched_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef enum logic [1:0] {
        REQ_RD  = 2'd0,
        REQ_WB0 = 2'd1,
        REQ_WB1 = 2'd2
    } req_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/rf_port_sched_if.sv
// Requester side of the register file port: one read, two write-backs.
// master = issue/write-back stages, slave = rf_port_sched.
interface rf_port_sched_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_rs1;
    logic [AW-1:0] rd_rs2;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data1;
    logic [DW-1:0] rsp_data2;
    logic          wb0_valid;
    logic          wb0_ready;
    logic [AW-1:0] wb0_rd;
    logic [DW-1:0] wb0_data;
    logic          wb1_valid;
    logic          wb1_ready;
    logic [AW-1:0] wb1_rd;
    logic [DW-1:0] wb1_data;

    modport master (
        output rd_valid, rd_rs1, rd_rs2,
        input  rd_ready, rsp_valid, rsp_data1, rsp_data2,
        output wb0_valid, wb0_rd, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb1_ready
    );

    modport slave (
        input  rd_valid, rd_rs1, rd_rs2,
        output rd_ready, rsp_valid, rsp_data1, rsp_data2,
        input  wb0_valid, wb0_rd, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb1_ready
    );

endinterface

// File: rtl/rf_port_sched_arb3.sv
// 3-way round-robin arbiter; search starts at the pointer,
// pointer moves past the winner, holds when nothing is granted.
module rf_rr_arb3
    import rf_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [2:0] req,
    input  logic [2:0] mask,
    output logic [2:0] gnt
);

    req_e       ptr;
    logic [2:0] act;

    assign act = req & ~mask & {3{en}};

    // Pick the first active request at or after the pointer.
    always_comb begin
        gnt = 3'b000;
        unique case (ptr)
            REQ_RD: begin
                if (act[0])      gnt = 3'b001;
                else if (act[1]) gnt = 3'b010;
                else if (act[2]) gnt = 3'b100;
            end
            REQ_WB0: begin
                if (act[1])      gnt = 3'b010;
                else if (act[2]) gnt = 3'b100;
                else if (act[0]) gnt = 3'b001;
            end
            REQ_WB1: begin
                if (act[2])      gnt = 3'b100;
                else if (act[0]) gnt = 3'b001;
                else if (act[1]) gnt = 3'b010;
            end
            default: gnt = 3'b000;
        endcase
    end

    // Advance the pointer to the slot after the winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= REQ_RD;
        end else begin
            unique case (1'b1)
                gnt[0]:  ptr <= REQ_WB0;
                gnt[1]:  ptr <= REQ_WB1;
                gnt[2]:  ptr <= REQ_RD;
                default: ptr <= ptr;
            endcase
        end
    end

endmodule

// File: rtl/rf_port_sched.sv
// Shares the register file port between one reader and two write-backs.
// Build macro RF_SCHED_X0_ZERO_EN makes register 0 read-as-zero.
module rf_port_sched
    import rf_sched_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    rf_port_sched_if.slave bus,
    output logic          rf_reset,
    output logic          rf_we,
    output logic [AW-1:0] rf_rs1,
    output logic [AW-1:0] rf_rs2,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rs1_out,
    input  logic [DW-1:0] rf_rs2_out
);

    state_e        state;
    state_e        state_nx;
    logic          run;
    logic [2:0]    gnt;
    logic [2:0]    mask;
    logic          wb0_zero;
    logic          wb1_zero;
    logic          raw0;
    logic          raw1;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;
    logic          rsp_q;

`ifdef RF_SCHED_X0_ZERO_EN
    assign wb0_zero = (bus.wb0_rd == '0);
    assign wb1_zero = (bus.wb1_rd == '0);
`else
    assign wb0_zero = 1'b0;
    assign wb1_zero = 1'b0;
`endif

    assign raw0 = bus.wb0_valid & ~wb0_zero &
                  ((bus.wb0_rd == bus.rd_rs1) | (bus.wb0_rd == bus.rd_rs2));
    assign raw1 = bus.wb1_valid & ~wb1_zero &
                  ((bus.wb1_rd == bus.rd_rs1) | (bus.wb1_rd == bus.rd_rs2));

    // Zero-register writes bypass the port; a pending write hides the read.
    assign mask = {wb1_zero, wb0_zero, raw0 | raw1};

    rf_rr_arb3 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run),
        .req     ({bus.wb1_valid, bus.wb0_valid, bus.rd_valid}),
        .mask    (mask),
        .gnt     (gnt)
    );

    // State register: reset always lands in the one-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_CLEAR;
        else          state <= state_nx;
    end

    // Next state: CLEAR hands over to RUN, which is terminal.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_CLEAR: state_nx = ST_RUN;
            ST_RUN:   state_nx = ST_RUN;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    // FSM outputs: clear pulse to the file, arbitration enable.
    always_comb begin
        run      = (state == ST_RUN);
        rf_reset = (state == ST_CLEAR);
    end

    assign bus.rd_ready  = gnt[0];
    assign bus.wb0_ready = gnt[1] | (run & bus.wb0_valid & wb0_zero);
    assign bus.wb1_ready = gnt[2] | (run & bus.wb1_valid & wb1_zero);

    // Write port mux; idle and read cycles drive zero.
    always_comb begin
        rf_we    = gnt[1] | gnt[2];
        rf_rd    = '0;
        rf_wdata = '0;
        unique case (1'b1)
            gnt[1]: begin
                rf_rd    = bus.wb0_rd;
                rf_wdata = bus.wb0_data;
            end
            gnt[2]: begin
                rf_rd    = bus.wb1_rd;
                rf_wdata = bus.wb1_data;
            end
            default: ;
        endcase
    end

    assign rf_rs1 = gnt[0] ? bus.rd_rs1 : rs1_q;
    assign rf_rs2 = gnt[0] ? bus.rd_rs2 : rs2_q;

    // Remember the last read addresses and flag the response cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs1_q <= '0;
            rs2_q <= '0;
            rsp_q <= 1'b0;
        end else begin
            rs1_q <= rf_rs1;
            rs2_q <= rf_rs2;
            rsp_q <= gnt[0];
        end
    end

    assign bus.rsp_valid = rsp_q;

`ifdef RF_SCHED_X0_ZERO_EN
    assign bus.rsp_data1 = (rs1_q == '0) ? '0 : rf_rs1_out;
    assign bus.rsp_data2 = (rs2_q == '0) ? '0 : rf_rs2_out;
`else
    assign bus.rsp_data1 = rf_rs1_out;
    assign bus.rsp_data2 = rf_rs2_out;
`endif

endmodule
